// File: rtl/hilo_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU; quotient to LO, remainder to HI.
// Optional signed support is enabled by defining HILO_DIV_SIGNED_EN.
module hilo_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;

  logic             w_accept;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;

  // Partial remainder stays below 2*|divisor|, so the (WIDTH+1)-bit difference sign alone decides restore.
  assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
  assign w_diff      = w_shift_rem - {1'b0, r_dvs};
  assign w_rem_next  = w_diff[WIDTH] ? w_shift_rem[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_next  = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};

`ifdef HILO_DIV_SIGNED_EN
  logic r_qneg;
  logic r_rneg;
  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = signed_i & dividend_i[WIDTH-1];
  assign w_b_neg = signed_i & divisor_i[WIDTH-1];
  assign w_a_mag = neg_if(dividend_i, w_a_neg);
  assign w_b_mag = neg_if(divisor_i, w_b_neg);
  assign w_q_fix = neg_if(w_quo_next, r_qneg);
  assign w_r_fix = neg_if(w_rem_next, r_rneg);

  // Result sign flags captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (w_accept) begin
      r_qneg <= w_a_neg ^ w_b_neg;
      r_rneg <= w_a_neg;
    end
  end
`else
  assign w_a_mag = dividend_i;
  assign w_b_mag = divisor_i;
  // signed_i has no effect in the unsigned-only build.
  assign w_q_fix = w_quo_next ^ {WIDTH{signed_i & 1'b0}};
  assign w_r_fix = w_rem_next;
`endif

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem <= '0;
            r_quo <= w_a_mag;
            r_dvs <= w_b_mag;
            r_cnt <= '0;
            if (divisor_i == {WIDTH{1'b0}}) begin
              r_state     <= S_DONE;
              quotient_o  <= {WIDTH{1'b1}};
              remainder_o <= dividend_i;
            end else begin
              r_state <= S_ON;
            end
          end
        end
        S_ON: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_STEP) begin
              r_state     <= S_DONE;
              quotient_o  <= w_q_fix;
              remainder_o <= w_r_fix;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o = !rst && (((r_state == S_IDLE) && start_i && !annul_i) || (r_state == S_ON));
  assign busy_o  = (r_state == S_ON) || (r_state == S_DONE);
  assign ready_o = (r_state == S_DONE) && !annul_i;

endmodule

// File: tb/tb_hilo_divider.sv
// Randomized scoreboard bench for hilo_divider against a plain-arithmetic division model.
module tb_hilo_divider;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        annul_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        stall_o;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;

  hilo_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .annul_i     (annul_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .stall_o     (stall_o),
    .busy_o      (busy_o),
    .ready_o     (ready_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rdy_last = 0;
  logic [31:0] last_q = 32'd0;
  logic [31:0] last_r = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: quotient/remainder straight from integer division.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end
`ifdef HILO_DIV_SIGNED_EN
    else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end
`endif
    else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitor: every ready_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient_o, e.q);
        chk("remainder", remainder_o, e.r);
        chk("ready_cycle", cyc, e.cyc);
        rdy_last = cyc;
      end
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    int   acc;
    bit   seen;
    @(negedge clk);
    start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b; annul_i = 1'b0;
    acc = cyc;
    ref_div(a, b, s, e.q, e.r);
    e.cyc = acc + ((b == 32'd0) ? 1 : 33);
    sb.push_back(e);
    last_q = e.q;
    last_r = e.r;
    #1 chk("stall_accept", {31'd0, stall_o}, 32'd1);
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (ready_o) begin
        seen = 1'b1;
        chk("stall_done", {31'd0, stall_o}, 32'd0);
      end else if (b != 32'd0 && k <= 32) begin
        chk("stall_on", {31'd0, stall_o}, 32'd1);
      end
    end
    if (!seen) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("idle_busy", {31'd0, busy_o}, 32'd0);
    chk("idle_ready", {31'd0, ready_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1;
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    dividend_i = 32'd0; divisor_i = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_q", quotient_o, 32'd0);
    chk("rst_r", remainder_o, 32'd0);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0);
    go_idle();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    go_idle();
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0);
    go_idle();
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    go_idle();
    run_div(32'h0000_1234, 32'd0, 1'b0);
    go_idle();

    // Annul in cycle 10, new start in cycle 12.
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd5000; divisor_i = 32'd3;
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    #1;
    chk("annul_busy", {31'd0, busy_o}, 32'd0);
    chk("annul_ready", {31'd0, ready_o}, 32'd0);
    chk("annul_q_hold", quotient_o, last_q);
    chk("annul_r_hold", remainder_o, last_r);
    run_div(32'd1000, 32'd9, 1'b0);
    go_idle();

    // Reset in cycle 20 of an operation.
    @(negedge clk);
    start_i = 1'b1; dividend_i = 32'd777; divisor_i = 32'd5;
    repeat (20) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_ready", {31'd0, ready_o}, 32'd0);
    chk("midrst_q", quotient_o, 32'd0);
    chk("midrst_r", remainder_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back with start_i held through DONE.
    run_div(32'hFFFF_FFFF, 32'h10, 1'b0);
    #1 r1 = rdy_last;
    run_div(32'd9, 32'd3, 1'b0);
    #1 chk("b2b_spacing", rdy_last - r1, 32'd34);
    go_idle();

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = $urandom;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
